// File: rtl/descriptor_serializer_pkg.sv
// Shared constants, FSM encoding and entry layout for the descriptor serializer.
// Header word layout: zero flag in the top bit, sequence index in the low bits.
package descriptor_serializer_pkg;

   localparam int WORD_W     = 32;
   localparam int BEATS      = 8;
   localparam int DESC_W     = WORD_W * BEATS;
   localparam int IDX_W      = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int BEAT_W     = $clog2(BEATS);
   localparam int ZERO_BIT   = WORD_W - 1;
   localparam int IDX_LSB    = 0;
   localparam int ENTRY_W    = DESC_W + IDX_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_PAY  = 2'd2;

   typedef struct packed {
      logic              zero;
      logic [IDX_W-1:0]  idx;
      logic [DESC_W-1:0] desc;
   } entry_t;

   function automatic logic [WORD_W-1:0] hdr_word(entry_t e);
      logic [WORD_W-1:0] w;
      w = '0;
      w[ZERO_BIT] = e.zero;
      w[IDX_LSB +: IDX_W] = e.idx;
      return w;
   endfunction

   function automatic logic [WORD_W-1:0] pay_word(logic [DESC_W-1:0] d, logic [BEAT_W-1:0] b);
      return d[int'(b)*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/descriptor_serializer_if.sv
// Output word stream of the descriptor serializer.
// A word transfers on a rising edge where m_valid and m_ready are both 1; once m_valid
// is raised, m_data/m_last hold and m_valid stays high until that transfer happens.
interface descriptor_serializer_if;
   import descriptor_serializer_pkg::*;

   logic [WORD_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/descriptor_serializer_desc_fifo.sv
// Synchronous FIFO holding tagged descriptors; exposes the head and the entry behind it
// so the serializer can load the following header in the same cycle it pops.
module desc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] next,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot, so a push while full is legal when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_ptr + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign next  = mem[rd_nxt];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/descriptor_serializer.sv
// Buffers 256-bit descriptors, tags them with a sequence index and streams each one
// as a header word plus BEATS payload words; lost descriptors are counted.
module descriptor_serializer
   import descriptor_serializer_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [DESC_W-1:0]        desc_in,
   input  logic                     desc_valid,
   descriptor_serializer_if.master  m,
   output logic                     fifo_full,
   output logic                     overflow,
   output logic [IDX_W-1:0]         drop_count,
   output logic [1:0]               fsm_state
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [1:0]        state;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] beat_nxt;
   logic [IDX_W-1:0]  seq_idx;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              push_req;
   logic              push;
   logic              final_hs;
   entry_t            push_entry;
   entry_t            head;
   entry_t            next_fifo;
   entry_t            next_entry;

   assign push_req   = ena & desc_valid;
   assign final_hs   = (state == S_PAY) && (beat == BEAT_W'(BEATS - 1)) && m.m_ready;
   assign push       = push_req && (!full || final_hs);
   assign push_entry = '{zero: (desc_in == '0), idx: seq_idx, desc: desc_in};
   assign beat_nxt   = beat + 1'b1;
   // Entry that becomes head after the pop: already queued, or arriving this very cycle.
   assign next_entry = (count > CNT_W'(1)) ? next_fifo : push_entry;
   assign fifo_full  = full;
   assign fsm_state  = state;

   desc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (final_hs),
      .din   (push_entry),
      .head  (head),
      .next  (next_fifo),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Dropped descriptors still consume an index so the gap is visible downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_idx    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push_req) seq_idx <= seq_idx + 1'b1;
         if (push_req && !push) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         beat      <= '0;
         m.m_valid <= 1'b0;
         m.m_data  <= '0;
         m.m_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  state     <= S_HDR;
                  m.m_valid <= 1'b1;
                  m.m_data  <= hdr_word(head);
                  m.m_last  <= 1'b0;
               end
            end
            S_HDR: begin
               if (m.m_ready) begin
                  state    <= S_PAY;
                  beat     <= '0;
                  m.m_data <= pay_word(head.desc, '0);
                  m.m_last <= (BEATS == 1);
               end
            end
            S_PAY: begin
               if (m.m_ready) begin
                  if (beat != BEAT_W'(BEATS - 1)) begin
                     beat     <= beat_nxt;
                     m.m_data <= pay_word(head.desc, beat_nxt);
                     m.m_last <= (beat_nxt == BEAT_W'(BEATS - 1));
                  end else if ((count > CNT_W'(1)) || push) begin
                     state    <= S_HDR;
                     m.m_data <= hdr_word(next_entry);
                     m.m_last <= 1'b0;
                  end else begin
                     state     <= S_IDLE;
                     m.m_valid <= 1'b0;
                     m.m_data  <= '0;
                     m.m_last  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               m.m_valid <= 1'b0;
               m.m_data  <= '0;
               m.m_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_descriptor_serializer.sv
// Bench for descriptor_serializer: table-driven descriptors plus hand-written
// stall, overflow, full-with-pop and mid-descriptor reset sequences.
module tb_descriptor_serializer;
   import descriptor_serializer_pkg::*;

   typedef struct {
      logic [DESC_W-1:0] desc;
      logic [WORD_W-1:0] exp_hdr;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ena = 1'b1;
   logic              desc_valid = 1'b0;
   logic [DESC_W-1:0] desc_in = '0;
   logic              fifo_full;
   logic              overflow;
   logic [IDX_W-1:0]  drop_count;
   logic [1:0]        fsm_state;

   descriptor_serializer_if sif();

   descriptor_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .desc_in    (desc_in),
      .desc_valid (desc_valid),
      .m          (sif),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .drop_count (drop_count),
      .fsm_state  (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int                n_vec = 0;
   int                n_err = 0;
   logic [WORD_W:0]   exp_q[$];
   logic [IDX_W-1:0]  model_idx = '0;
   logic              prev_stall = 1'b0;
   logic [WORD_W:0]   prev_word = '0;
   vec_t              vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_add(input logic [DESC_W-1:0] d, input logic [IDX_W-1:0] idx);
      logic [WORD_W-1:0] h;
      h = '0;
      h[WORD_W-1] = (d == '0);
      h[IDX_W-1:0] = idx;
      exp_q.push_back({1'b0, h});
      for (int i = 0; i < BEATS; i++)
         exp_q.push_back({(i == BEATS - 1), d[i*WORD_W +: WORD_W]});
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_desc(input logic [DESC_W-1:0] d, input bit accept);
      desc_in    = d;
      desc_valid = 1'b1;
      if (ena) begin
         if (accept) sb_add(d, model_idx);
         model_idx = model_idx + 1'b1;
      end
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic drain(input int budget, input bit rnd);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      sif.m_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"}, 64'(sif.m_valid), 64'd0);
      check({tag, "_m_data"}, 64'(sif.m_data), 64'd0);
      check({tag, "_m_last"}, 64'(sif.m_last), 64'd0);
      check({tag, "_fifo_full"}, 64'(fifo_full), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
      check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
      check({tag, "_fsm_state"}, 64'(fsm_state), 64'(S_IDLE));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      check_reset_outputs("rst");
      exp_q.delete();
      model_idx = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
   endtask

   function automatic logic [DESC_W-1:0] rand_desc();
      logic [DESC_W-1:0] d;
      for (int i = 0; i < BEATS; i++) d[i*WORD_W +: WORD_W] = $urandom;
      d[0] = 1'b1;
      return d;
   endfunction

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(sif.m_valid), 64'd1);
            check("hold_word", 64'({sif.m_last, sif.m_data}), 64'(prev_word));
         end
         if (sif.m_valid && sif.m_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 64'({sif.m_last, sif.m_data}), 64'h1_dead_beef);
            else check("stream_word", 64'({sif.m_last, sif.m_data}), 64'(exp_q.pop_front()));
         end
         prev_stall = sif.m_valid && !sif.m_ready;
         prev_word  = {sif.m_last, sif.m_data};
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [DESC_W-1:0] pat;
      logic [DESC_W-1:0] alt;
      for (int i = 0; i < BEATS; i++) begin
         pat[i*WORD_W +: WORD_W] = WORD_W'(i);
         alt[i*WORD_W +: WORD_W] = 32'hA5A5_0000 + WORD_W'(i * 17);
      end
      vecs[0] = '{pat,    32'h0000_0000};
      vecs[1] = '{'0,     32'h8000_0001};
      vecs[2] = '{'1,     32'h0000_0002};
      vecs[3] = '{alt,    32'h0000_0003};
      sif.m_ready = 1'b1;

      #1 rst = 1'b0;
      #2;
      check_reset_outputs("init");
      @(posedge clk);
      #1 rst = 1'b1;
      tick();

      // table: latency, header, 9 consecutive beats, m_last placement
      for (int i = 0; i < 4; i++) begin
         push_desc(vecs[i].desc, 1'b1);
         check("no_early_valid", 64'(sif.m_valid), 64'd0);
         tick();
         check("hdr_latency_valid", 64'(sif.m_valid), 64'd1);
         check("hdr_word", 64'(sif.m_data), 64'(vecs[i].exp_hdr));
         for (int b = 0; b < BEATS + 1; b++) begin
            check("beat_valid", 64'(sif.m_valid), 64'd1);
            check("beat_last", 64'(sif.m_last), 64'(b == BEATS));
            tick();
         end
         check("idle_after_last", 64'(sif.m_valid), 64'd0);
         drain(20, 1'b0);
      end

      // stall on payload beat 3
      push_desc(pat, 1'b1);
      repeat (5) tick();
      check("stall_pre_word", 64'(sif.m_data), 64'd3);
      sif.m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_valid", 64'(sif.m_valid), 64'd1);
         check("stall_word", 64'(sif.m_data), 64'd3);
         check("stall_last", 64'(sif.m_last), 64'd0);
      end
      sif.m_ready = 1'b1;
      drain(30, 1'b0);

      // ena low: strobe ignored, no index consumed
      ena = 1'b0;
      push_desc(rand_desc(), 1'b0);
      ena = 1'b1;
      repeat (4) begin
         tick();
         check("ena_off_idle", 64'(sif.m_valid), 64'd0);
      end

      // random descriptors under random back-pressure
      for (int k = 0; k < 6; k++) begin
         push_desc(rand_desc(), 1'b1);
         drain(400, 1'b1);
      end

      // overflow: six strobes into a stalled FIFO
      do_reset();
      sif.m_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push_desc(rand_desc(), k < 4);
         if (k == 2) check("full_after_3", 64'(fifo_full), 64'd0);
         if (k == 3) begin
            check("full_after_4", 64'(fifo_full), 64'd1);
            check("ovf_after_4", 64'(overflow), 64'd0);
            check("drops_after_4", 64'(drop_count), 64'd0);
         end
      end
      check("ovf_after_6", 64'(overflow), 64'd1);
      check("drops_after_6", 64'(drop_count), 64'd2);
      check("full_after_6", 64'(fifo_full), 64'd1);
      drain(100, 1'b0);
      check("ovf_sticky", 64'(overflow), 64'd1);
      check("full_drained", 64'(fifo_full), 64'd0);

      // full FIFO, push lands on the final-beat handshake
      sif.m_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_desc(rand_desc(), 1'b1);
      check("t5_full", 64'(fifo_full), 64'd1);
      sif.m_ready = 1'b1;
      repeat (8) tick();
      check("t5_last_valid", 64'(sif.m_valid), 64'd1);
      check("t5_last", 64'(sif.m_last), 64'd1);
      check("t5_still_full", 64'(fifo_full), 64'd1);
      push_desc(rand_desc(), 1'b1);
      check("t5_full_after", 64'(fifo_full), 64'd1);
      check("t5_drops", 64'(drop_count), 64'd2);
      check("t5_ovf", 64'(overflow), 64'd1);
      check("t5_next_valid", 64'(sif.m_valid), 64'd1);
      check("t5_next_hdr", 64'(sif.m_data), 64'h0000_0007);
      check("t5_next_last", 64'(sif.m_last), 64'd0);
      drain(100, 1'b0);

      // asynchronous reset during payload beat 5
      push_desc(pat, 1'b1);
      repeat (7) tick();
      check("t6_pre_word", 64'(sif.m_data), 64'd5);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("t6");
      exp_q.delete();
      model_idx = '0;
      @(posedge clk);
      #3 rst = 1'b1;
      repeat (4) begin
         tick();
         check("t6_no_stale", 64'(sif.m_valid), 64'd0);
      end
      push_desc(vecs[3].desc, 1'b1);
      tick();
      check("t6_hdr_valid", 64'(sif.m_valid), 64'd1);
      check("t6_hdr_idx0", 64'(sif.m_data), 64'h0000_0000);
      drain(30, 1'b0);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/descriptor_serializer.md
Name: descriptor_serializer

Overview:
- Sits directly downstream of the 4-lane descriptor generator and consumes its 256-bit descriptor and 1-cycle valid pulse.
- Buffers descriptors in a small FIFO, tags each one with a sequence index, and streams it out as 32-bit words over a valid/ready interface: one header word plus 8 payload words.
- Decouples the fixed-rate pixel pipeline from a back-pressured output bus (DMA/host link) and reports any loss.

Parameters:
- DESC_W, 256, descriptor width in bits; must equal WORD_W*BEATS.
- WORD_W, 32, output word width.
- BEATS, 8, payload words per descriptor.
- DEPTH, 4, FIFO entries (power of 2).
- IDX_W, 16, sequence index width; must be ≤ WORD_W-1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- ena, input, 1, input enable; when 0, desc_valid is ignored. The output side keeps draining.
- desc_in, input, DESC_W, descriptor from the generator.
- desc_valid, input, 1, 1-cycle strobe qualifying desc_in; no back-pressure is possible upstream.
- m_data, output, WORD_W, output word.
- m_valid, output, 1, m_data valid.
- m_ready, input, 1, downstream accepts the word.
- m_last, output, 1, marks the final payload word of a descriptor.
- fifo_full, output, 1, occupancy == DEPTH.
- overflow, output, 1, sticky; set on the first descriptor lost.
- drop_count, output, IDX_W, number of descriptors lost; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, FSM=IDLE, sequence index=0. All outputs are 0: m_data, m_valid, m_last, fifo_full=0, overflow=0, drop_count=0. Reset may arrive mid-descriptor; the partial descriptor is discarded and no further beats are emitted.
- Push:
  - push_req = ena & desc_valid.
  - The entry is written if occupancy < DEPTH, or if the final payload beat handshakes in the same cycle (the freed slot is reused).
  - Otherwise the descriptor is dropped: overflow<=1 and drop_count increments (saturating).
- Sequence index:
  - Each push_req stores the current index with the entry (dropped descriptors get none), then the index increments.
  - Dropped descriptors therefore still consume an index, so gaps are visible downstream.
  - The index wraps from all-ones to 0.
- Entry flag zero = (desc_in == 0). The generator emits an all-zero descriptor for corners it could not service.
- FSM states: IDLE, HDR, PAY.
  - IDLE: if FIFO not empty, move to HDR next cycle.
  - HDR: m_valid=1, m_data = {zero, (WORD_W-1-IDX_W) zeros, index}, m_last=0. On m_ready go to PAY with beat=0.
  - PAY: m_valid=1, m_data = desc[beat*WORD_W +: WORD_W] (LSW first), m_last = (beat==BEATS-1). On m_ready: if beat<BEATS-1, beat++; else pop the entry and go to HDR if another entry remains after the pop (a push in the same cycle counts), otherwise go to IDLE.
- Latency: a desc_valid at edge N with the FIFO empty and FSM in IDLE gives m_valid=1 with the header from the cycle after edge N+1. Back-to-back descriptors stream with no idle cycle between m_last and the next header.
- All outputs are registered. While m_valid=1 and m_ready=0, m_data and m_last hold stable. m_valid never drops without a handshake.
- A full descriptor is 9 beats. The sustained input rate must therefore average ≤ 1 descriptor per 9 cycles; bursts up to DEPTH are absorbed.
- fifo_full reflects occupancy after the current edge.
- overflow clears only on reset.

Decomposition:
- Shared package: DESC_W, WORD_W, BEATS, IDX_W constants, the FSM state encoding, and the header field offsets (ZERO_BIT = WORD_W-1, IDX_LSB = 0).
- One sub-module, desc_fifo: a synchronous FIFO of width DESC_W+IDX_W+1 and depth DEPTH. It has push/pop/full/empty/count, allows simultaneous push and pop when full, and uses the same asynchronous active-low reset.
- The FSM, beat counter, index counter and drop logic stay in descriptor_serializer.

Test Plan:
1. Single descriptor with desc_in = 256'h0123…(pattern words 0x00000000..0x00000007 in LSW-first order), m_ready=1 → header 0x00000000, then payload words 0,1,…,7; m_last only on word 7; 9 consecutive beats.
2. All-zero descriptor as the second push → header 0x80000001, eight 0x00000000 payload words.
3. m_ready=0 for 5 cycles during beat 3 → m_data stays 0x00000003 and m_valid stays 1; the stream then resumes with no loss or duplication.
4. m_ready=0, 6 strobes 1 cycle apart → fifo_full=1 after the 4th; overflow=1 and drop_count=2. When draining, headers read indices 0,1,2,3 and the next accepted push gets index 6.
5. FIFO full and the final beat handshakes in the same cycle as desc_valid → the push is accepted, drop_count does not increment, and the next header follows m_last immediately.
6. rst pulsed low during beat 5 → all outputs go to 0 immediately (asynchronously); after release no stale beats appear, and the next descriptor's header shows index 0.
